// File: rtl/slave_b_channel_resp_queue.sv
// slave_b_channel_resp_queue
// Merges write responses from the error path (source 1) and the posted-write
// path (source 2) into one AXI4 slave B channel. A round-robin arbiter selects
// one source per cycle. The granted response goes into a first-word-fall-through
// FIFO, and the FIFO head drives BVALID/BRESP/BID with a full handshake.
// Optional feature macro: SLAVE_B_RESP_ERR_CNT_EN adds a saturating err_count
// output. The counter advances on every delivered SLVERR or DECERR response.
module slave_b_channel_resp_queue #(
  parameter int ID_WIDTH  = 4,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      in1_bvalid,
  input  logic [1:0]                in1_bresp,
  input  logic [ID_WIDTH-1:0]       in1_bid,
  output logic                      in1_bready,
  input  logic                      in2_bvalid,
  input  logic [1:0]                in2_bresp,
  input  logic [ID_WIDTH-1:0]       in2_bid,
  output logic                      in2_bready,
  output logic                      BVALID,
  output logic [1:0]                BRESP,
  output logic [ID_WIDTH-1:0]       BID,
  input  logic                      BREADY,
  output logic [$clog2(DEPTH):0]    q_count
`ifdef SLAVE_B_RESP_ERR_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ID_WIDTH + 2;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [EW-1:0] r_mem [DEPTH];
  // 0: source 1 wins a tie, 1: source 2 wins a tie
  logic          r_prio;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_space;
  logic          w_gnt1;
  logic          w_gnt2;
  logic          w_push;
  logic [EW-1:0] w_push_data;
  logic [EW-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // BVALID depends only on the registered pointers. This keeps it free of any
  // combinational path from the inputs and from BREADY.
  assign BVALID  = !w_empty;
  assign w_pop   = BVALID && BREADY;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  // Reset holds both ready outputs low.
  assign w_space = !arst && (!w_full || w_pop);

  // Round-robin grant. Only one source is pushed per cycle.
  always_comb begin
    w_gnt1 = 1'b0;
    w_gnt2 = 1'b0;
    if (w_space) begin
      if (in1_bvalid && in2_bvalid) begin
        if (r_prio == 1'b0) w_gnt1 = 1'b1;
        else                w_gnt2 = 1'b1;
      end else if (in1_bvalid) begin
        w_gnt1 = 1'b1;
      end else if (in2_bvalid) begin
        w_gnt2 = 1'b1;
      end
    end
  end

  assign in1_bready  = w_gnt1;
  assign in2_bready  = w_gnt2;
  assign w_push      = w_gnt1 || w_gnt2;
  assign w_push_data = w_gnt1 ? {in1_bresp, in1_bid} : {in2_bresp, in2_bid};

  // Pointer and priority state. Reset clears the queue asynchronously.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_prio   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_gnt1)      r_prio <= 1'b1;
      else if (w_gnt2) r_prio <= 1'b0;
    end
  end

  // Storage array. The pointers alone decide which entries are valid, so the
  // array itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
  end

  // The head entry is shown only while the queue holds data. When empty,
  // BRESP and BID read as zero, which is also their reset value.
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign BRESP   = w_empty ? 2'b00 : w_head[EW-1 -: 2];
  assign BID     = w_empty ? '0 : w_head[ID_WIDTH-1:0];
  assign q_count = r_wr_ptr - r_rd_ptr;

`ifdef SLAVE_B_RESP_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] r_err_count;

  // Count delivered SLVERR/DECERR responses and hold at all-ones.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_err_count <= '0;
    end else if (w_pop && BRESP[1] && (r_err_count != {CNT_WIDTH{1'b1}})) begin
      r_err_count <= r_err_count + CNT_WIDTH'(1);
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: doc/slave_b_channel_resp_queue.md
Name: slave_b_channel_resp_queue

Overview:
Downstream of the slave internal write-response mux. Accepts B-channel responses from two internal sources: the error path (source 1) and the posted-write path (source 2). Arbitrates fairly between them and buffers granted responses in a FIFO. Drives the AXI4 slave B channel toward the master with a full BVALID/BREADY handshake, so a stalled master never drops a response.

Parameters:
ID_WIDTH, 4, width of BID
DEPTH, 8, FIFO entries; power of 2, >= 2
CNT_WIDTH, 16, width of optional error counter

Ports:
clk  input  1  single clock, all logic rising-edge
arst  input  1  asynchronous, active-high reset
in1_bvalid  input  1  error-source response valid
in1_bresp  input  2  error-source BRESP
in1_bid  input  ID_WIDTH  error-source BID
in1_bready  output  1  error-source accepted this cycle
in2_bvalid  input  1  posted-source response valid
in2_bresp  input  2  posted-source BRESP
in2_bid  input  ID_WIDTH  posted-source BID
in2_bready  output  1  posted-source accepted this cycle
BVALID  output  1  AXI B valid to master
BRESP  output  2  AXI B response (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR)
BID  output  ID_WIDTH  AXI B ID
BREADY  input  1  AXI B ready from master
q_count  output  $clog2(DEPTH)+1  current FIFO occupancy
err_count  output  CNT_WIDTH  present only with the optional feature

Behaviour:
- Reset (arst=1, asynchronous): FIFO empty; wr_ptr=rd_ptr=0; q_count=0; BVALID=0; BRESP=2'b00; BID=0; in1_bready=in2_bready=0; RR priority pointer = source 1; err_count=0.
- Input handshake: a transfer on source k occurs when ink_bvalid && ink_bready. A source holds bresp/bid stable while valid is high and not accepted.
- Arbiter (combinational grant, registered priority):
  - Grant only when the FIFO is not full, or is full and a pop occurs this cycle (pop-through-full allowed).
  - One valid source: that source is granted.
  - Both valid: grant the source at the priority pointer. After each grant, the pointer moves to the other source.
  - At most one push per cycle.
  - ink_bready is high only for the granted source.
- FIFO:
  - Push writes {bresp,bid} at wr_ptr; pop advances rd_ptr.
  - Pointers are $clog2(DEPTH)+1 bits with a wrap bit. Full = indices equal and wrap bits differ; empty = pointers equal.
  - Simultaneous push and pop leaves q_count unchanged.
- Output:
  - BVALID = !empty, first-word-fall-through; BRESP/BID come from the rd_ptr entry.
  - Pop when BVALID && BREADY.
  - Latency: an accepted input appears on BVALID at the next rising edge when the FIFO was empty (1 cycle). No combinational path from in*_bvalid to BVALID.
  - BVALID, once high, stays high with stable BRESP/BID until BREADY (AXI rule). The BVALID path is independent of BREADY.
- Ordering: responses leave in grant order. No reordering by ID.
- Empty with BREADY=1: no pop, no pointer change.
- Reset mid-transfer: all pending entries are discarded and BVALID drops asynchronously.

Optional Feature:
Macro SLAVE_B_RESP_ERR_CNT_EN.
- Defined:
  - err_count port exists. It increments by 1 on each output handshake with BRESP[1]=1 (SLVERR or DECERR).
  - Saturates at all-ones. Reset to 0.
- Undefined: the err_count port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Single response: in1 valid, bresp=10, bid=3, BREADY=1 -> in1_bready=1 that cycle; next cycle BVALID=1, BRESP=10, BID=3; then BVALID=0.
- Contention: in1 and in2 valid together for 4 cycles, each presenting a new ID on acceptance, BREADY=1 -> grants alternate 1,2,1,2; BID order matches.
- Back-pressure to full: BREADY=0, push 8 responses from in2 -> q_count=8 and in2_bready=0. Then BREADY=1 -> 8 responses drain in order, and BVALID/BRESP/BID stay stable during stall cycles.
- Full with simultaneous pop: full FIFO, BREADY=1, in1 valid -> in1 accepted the same cycle and q_count stays 8.
- Async reset: 5 entries queued, BVALID=1, assert arst mid-cycle -> BVALID=0 immediately, q_count=0; after release the first new input appears with 1-cycle latency.
- Optional: with SLAVE_B_RESP_ERR_CNT_EN and CNT_WIDTH=2, drain responses 10, 11, 00, 10, 10 -> err_count=3 (saturated); without the macro the bench compiles and no err_count port exists.
